// File: rtl/tdm_demux_1x4_4bit.sv
// 1-to-4 TDM demultiplexer with manual or slot-counter routing.
// Per-channel valid/ack handshake, frame pulse and sticky overrun.
module tdm_demux_1x4_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             s0,
  input  logic             s1,
  input  logic             auto_mode,
  input  logic             sync,
  input  logic [3:0]       ack,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       v,
  output logic             frame_done,
  output logic             overrun
);

  logic [WIDTH-1:0] ch_q [4];
  logic [3:0]       v_q;
  logic [3:0]       hit;
  logic [1:0]       slot_q;
  logic [1:0]       slot_d;
  logic [1:0]       tgt;
  logic             fd_q;
  logic             ovr_q;

  // sync realigns the frame, so an auto capture with sync goes to slot 0
  assign tgt = auto_mode ? (sync ? 2'd0 : slot_q)
                         : {s1, s0};

  assign hit = din_valid ? (4'b0001 << tgt) : 4'b0000;

  always_comb begin
    slot_d = slot_q;
    if (din_valid && auto_mode)
      slot_d = sync ? 2'd1 : slot_q + 2'd1;
    else if (sync)
      slot_d = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        ch_q[i] <= '0;
      v_q    <= 4'b0000;
      slot_q <= 2'd0;
      fd_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (hit[i])
          ch_q[i] <= din;
      v_q    <= hit | (v_q & ~ack);
      slot_q <= slot_d;
      fd_q   <= din_valid & auto_mode
              & (tgt == 2'd3);
      ovr_q  <= ovr_q | (|(hit & v_q & ~ack));
    end
  end

  assign o0         = ch_q[0];
  assign o1         = ch_q[1];
  assign o2         = ch_q[2];
  assign o3         = ch_q[3];
  assign v          = v_q;
  assign frame_done = fd_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_tdm_demux_1x4_4bit.sv
// Bench for tdm_demux_1x4_4bit: per-cycle reference model
// compare plus directed vectors with literal expectations.
module tb_tdm_demux_1x4_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       s0;
  logic       s1;
  logic       auto_mode;
  logic       sync;
  logic [3:0] ack;
  logic [3:0] o0;
  logic [3:0] o1;
  logic [3:0] o2;
  logic [3:0] o3;
  logic [3:0] v;
  logic       frame_done;
  logic       overrun;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] mo [4];
  logic [3:0] mv;
  logic       mfd;
  logic       movr;
  int         mslot;

  tdm_demux_1x4_4bit #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .s0(s0),
    .s1(s1),
    .auto_mode(auto_mode),
    .sync(sync),
    .ack(ack),
    .o0(o0),
    .o1(o1),
    .o2(o2),
    .o3(o3),
    .v(v),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  // Reference model: channel array, valid set, slot as an integer mod 4
  always @(posedge clk or posedge rst) begin : model
    int t;
    if (rst) begin
      for (int i = 0; i < 4; i++)
        mo[i] <= 4'h0;
      mv    <= 4'h0;
      mfd   <= 1'b0;
      movr  <= 1'b0;
      mslot <= 0;
    end else begin
      t = -1;
      if (din_valid) begin
        if (!auto_mode)
          t = 2 * int'(s1) + int'(s0);
        else if (sync)
          t = 0;
        else
          t = mslot;
      end
      for (int i = 0; i < 4; i++) begin
        if (i == t) begin
          mo[i] <= din;
          mv[i] <= 1'b1;
          if (mv[i] && !ack[i])
            movr <= 1'b1;
        end else if (ack[i]) begin
          mv[i] <= 1'b0;
        end
      end
      mfd <= (t == 3) && auto_mode;
      if (din_valid && auto_mode)
        mslot <= sync ? 1 : (mslot + 1) % 4;
      else if (sync)
        mslot <= 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_o0", o0, mo[0]);
      chk("cmp_o1", o1, mo[1]);
      chk("cmp_o2", o2, mo[2]);
      chk("cmp_o3", o3, mo[3]);
      chk("cmp_v", v, mv);
      chk("cmp_fd", {3'b0, frame_done}, {3'b0, mfd});
      chk("cmp_ovr", {3'b0, overrun}, {3'b0, movr});
    end
  end

  task automatic drive(input logic [3:0] d,
                       input logic dv,
                       input logic [1:0] s,
                       input logic am,
                       input logic sy,
                       input logic [3:0] ak);
    @(negedge clk);
    din       = d;
    din_valid = dv;
    s1        = s[1];
    s0        = s[0];
    auto_mode = am;
    sync      = sy;
    ack       = ak;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
    ack       = 4'h0;
  endtask

  task automatic idle();
    drive(4'h0, 1'b0, 2'd0, auto_mode, 1'b0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_o0"}, o0, 4'h0);
    chk({nm, "_o1"}, o1, 4'h0);
    chk({nm, "_o2"}, o2, 4'h0);
    chk({nm, "_o3"}, o3, 4'h0);
    chk({nm, "_v"}, v, 4'h0);
    chk({nm, "_fd"}, {3'b0, frame_done}, 4'h0);
    chk({nm, "_ovr"}, {3'b0, overrun}, 4'h0);
  endtask

  initial begin
    rst = 1'b1;
    din = 4'h0;
    din_valid = 1'b0;
    s0 = 1'b0;
    s1 = 1'b0;
    auto_mode = 1'b0;
    sync = 1'b0;
    ack = 4'h0;
    #2;
    chk_zero("rst_init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // manual routing
    drive(4'hA, 1'b1, 2'd0, 1'b0, 1'b0, 4'h0);
    drive(4'hF, 1'b1, 2'd1, 1'b0, 1'b0, 4'h0);
    drive(4'h0, 1'b1, 2'd2, 1'b0, 1'b0, 4'h0);
    drive(4'h5, 1'b1, 2'd3, 1'b0, 1'b0, 4'h0);
    chk("man_o0", o0, 4'hA);
    chk("man_o1", o1, 4'hF);
    chk("man_o2", o2, 4'h0);
    chk("man_o3", o3, 4'h5);
    chk("man_v", v, 4'hF);
    chk("man_ovr", {3'b0, overrun}, 4'h0);
    drive(4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h2);
    chk("ack_v", v, 4'hD);
    chk("ack_keep", o1, 4'hF);

    // inputs ignored while rst held
    @(negedge clk);
    rst = 1'b1;
    din = 4'h7;
    din_valid = 1'b1;
    auto_mode = 1'b1;
    @(negedge clk);
    chk_zero("rst_hold");
    din_valid = 1'b0;
    rst = 1'b0;

    // auto frame
    drive(4'h1, 1'b1, 2'd0, 1'b1, 1'b1, 4'h0);
    chk("af_fd0", {3'b0, frame_done}, 4'h0);
    drive(4'h2, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0);
    drive(4'h3, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0);
    drive(4'h4, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0);
    chk("af_fd", {3'b0, frame_done}, 4'h1);
    chk("af_o0", o0, 4'h1);
    chk("af_o1", o1, 4'h2);
    chk("af_o2", o2, 4'h3);
    chk("af_o3", o3, 4'h4);
    chk("af_v", v, 4'hF);
    idle();
    chk("af_fd_off", {3'b0, frame_done}, 4'h0);
    drive(4'h0, 1'b0, 2'd0, 1'b1, 1'b0, 4'hF);
    chk("af_ackall", v, 4'h0);
    drive(4'h8, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0);
    chk("af_wrap", o0, 4'h8);
    chk("af_ovr", {3'b0, overrun}, 4'h0);

    // mode switch mid-frame keeps slot
    drive(4'h6, 1'b1, 2'd3, 1'b0, 1'b0, 4'h0);
    chk("sw_o3", o3, 4'h6);
    drive(4'h9, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0);
    chk("sw_o1", o1, 4'h9);
    chk("sw_v", v, 4'hB);

    // ack/capture collision
    do_reset();
    drive(4'h5, 1'b1, 2'd2, 1'b0, 1'b0, 4'h0);
    drive(4'h9, 1'b1, 2'd2, 1'b0, 1'b0, 4'h5);
    chk("col_o2", o2, 4'h9);
    chk("col_v", v, 4'h4);
    chk("col_ovr", {3'b0, overrun}, 4'h0);
    drive(4'h0, 1'b0, 2'd2, 1'b0, 1'b0, 4'h4);
    chk("col_clr", v, 4'h0);
    chk("col_keep", o2, 4'h9);

    // overrun sticky
    do_reset();
    drive(4'h3, 1'b1, 2'd1, 1'b0, 1'b0, 4'h0);
    chk("ovr_pre", {3'b0, overrun}, 4'h0);
    drive(4'h7, 1'b1, 2'd1, 1'b0, 1'b0, 4'h0);
    chk("ovr_o1", o1, 4'h7);
    chk("ovr_set", {3'b0, overrun}, 4'h1);
    repeat (10) idle();
    drive(4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 4'hF);
    chk("ovr_stick", {3'b0, overrun}, 4'h1);

    // async reset between edges mid-frame
    do_reset();
    drive(4'h1, 1'b1, 2'd0, 1'b1, 1'b1, 4'h0);
    drive(4'h2, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("arst");
    #1 rst = 1'b0;
    drive(4'hC, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0);
    chk("arst_o0", o0, 4'hC);
    chk("arst_v", v, 4'h1);

    // sync mid-frame
    do_reset();
    drive(4'h1, 1'b1, 2'd0, 1'b1, 1'b1, 4'h0);
    drive(4'h2, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0);
    drive(4'hE, 1'b1, 2'd0, 1'b1, 1'b1, 4'h0);
    chk("msync_o0", o0, 4'hE);
    drive(4'h5, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0);
    chk("msync_o1", o1, 4'h5);

    // sync in manual mode resets slot
    do_reset();
    drive(4'h1, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0);
    drive(4'h0, 1'b0, 2'd2, 1'b0, 1'b1, 4'h0);
    chk("msy_v", v, 4'h1);
    drive(4'h7, 1'b1, 2'd0, 1'b1, 1'b0, 4'h0);
    chk("msy_o0", o0, 4'h7);
    chk("msy_o1", o1, 4'h0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
